// File: rtl/trivium_uart_defs.sv
// rtl/trivium_uart_defs.sv - shared constants for the Trivium UART link
// Receiver state encodings, byte width and bit-period computation.
package trivium_uart_defs;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/cipher_rx_frame.sv
// rtl/cipher_rx_frame.sv - 8N1 UART receiver with input synchroniser
// Emits a one-cycle rx_done with the received byte, or frame_err on a low stop bit.
module cipher_rx_frame
  import trivium_uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              serial_in,
  output logic              rx_done,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic              sync_q1;
  logic              rx_s;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shift_q;

  // The shift register is untouched between the stop sample and the next
  // frame's first data bit, so it can be presented directly as the byte.
  assign rx_byte = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q1   <= serial_in;
      rx_s      <= sync_q1;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ena && !rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shift_q <= {rx_s, shift_q[BYTE_W-1:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a stuck-low line cannot retrigger.
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/trivium_rx_decrypt.sv
// rtl/trivium_rx_decrypt.sv - UART ciphertext receiver with Trivium keystream XOR
// Single-entry pending stage feeding a valid/ready plaintext output register.
module trivium_rx_decrypt
  import trivium_uart_defs::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              serial_in,
  input  logic [BYTE_W-1:0] keystream_byte,
  input  logic              keystream_valid,
  output logic              keystream_read,
  output logic [BYTE_W-1:0] pt_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              sync_lost
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  logic              rx_done;
  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] cipher_q;
  logic              cipher_pending;
  logic              decrypt_fire;
  logic              drop_byte;

  cipher_rx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .serial_in(serial_in),
    .rx_done  (rx_done),
    .rx_byte  (rx_byte),
    .frame_err(frame_err)
  );

  // keystream_read is combinational so the generator advances in the same
  // cycle its byte is used; a registered strobe would let a reloaded pending
  // byte reuse stale keystream.
  assign decrypt_fire   = cipher_pending && keystream_valid && (!pt_valid || pt_ready);
  assign drop_byte      = rx_done && cipher_pending && !decrypt_fire;
  assign keystream_read = decrypt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipher_q       <= '0;
      cipher_pending <= 1'b0;
      pt_data        <= '0;
      pt_valid       <= 1'b0;
      overrun        <= 1'b0;
      sync_lost      <= 1'b0;
    end else begin
      overrun <= drop_byte;
      if (frame_err || drop_byte) begin
        sync_lost <= 1'b1;
      end

      if (rx_done && !drop_byte) begin
        cipher_q       <= rx_byte;
        cipher_pending <= 1'b1;
      end else if (decrypt_fire) begin
        cipher_pending <= 1'b0;
      end

      if (decrypt_fire) begin
        pt_data  <= cipher_q ^ keystream_byte;
        pt_valid <= 1'b1;
      end else if (pt_ready) begin
        pt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trivium_rx_decrypt.sv
// tb/tb_trivium_rx_decrypt.sv - self-checking bench for trivium_rx_decrypt
// Expected-plaintext queue plus per-cycle protocol monitor and directed scenarios.
module tb_trivium_rx_decrypt;

  localparam int CPB = 16;
  // start-of-frame drive to pt_valid rise: 2 sync + 1 idle detect + half bit + 9 bits + 2
  localparam int LATENCY = 3 + CPB / 2 + 9 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] keystream_byte = 8'h00;
  logic       keystream_valid = 1'b0;
  logic       keystream_read;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       sync_lost;

  trivium_rx_decrypt #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .serial_in      (serial_in),
    .keystream_byte (keystream_byte),
    .keystream_valid(keystream_valid),
    .keystream_read (keystream_read),
    .pt_data        (pt_data),
    .pt_valid       (pt_valid),
    .pt_ready       (pt_ready),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .sync_lost      (sync_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int n_read = 0, n_ferr = 0, n_ovr = 0, n_acc = 0;
  int last_rise_cyc = 0;
  int frame_start = 0;
  logic [7:0] last_acc = 8'h00;
  logic hold_prev = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] hold_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: ordering against the model queue, hold stability, event counts.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      hold_prev  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", pt_valid, 1);
        check("hold_data", pt_data, hold_data);
      end
      if (keystream_read) begin
        n_read++;
        check("read_without_valid", keystream_valid, 1);
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (pt_valid && !prev_valid) last_rise_cyc = cyc;
      if (pt_valid && pt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pt_unexpected: got 0x%0h expected no byte", pt_data);
        end else begin
          check("pt_order", pt_data, exp_q.pop_front());
          n_acc++;
          last_acc = pt_data;
        end
      end
      hold_prev  = pt_valid && !pt_ready;
      hold_data  = pt_data;
      prev_valid = pt_valid;
    end
  end

  // abort_bit >= 0 asserts reset halfway through that data bit and returns.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int abort_bit);
    @(negedge clk);
    serial_in   = 1'b0;
    frame_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      if (i == abort_bit) begin
        repeat (CPB / 2) @(negedge clk);
        rst_n     = 1'b0;
        serial_in = 1'b1;
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    if (stop_low > 0) begin
      serial_in = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n = 0;
    while (n_acc < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, (n_acc >= target) ? 1 : 0, 1);
  endtask

  task automatic send_expect(input logic [7:0] c, input logic [7:0] ks);
    exp_q.push_back(c ^ ks);
    send_frame(c, 0, -1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, o0, a0;

    repeat (3) @(negedge clk);
    check("rst_pt_valid", pt_valid, 0);
    check("rst_pt_data", pt_data, 8'h00);
    check("rst_ks_read", keystream_read, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sync_lost", sync_lost, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: basic decrypt and latency
    keystream_byte = 8'h3C; keystream_valid = 1'b1; pt_ready = 1'b1;
    r0 = n_read; f0 = n_ferr; o0 = n_ovr; a0 = n_acc;
    send_expect(8'hA5, 8'h3C);
    wait_acc("t1_accept", a0 + 1, 300);
    check("t1_pt_data", last_acc, 8'h99);
    check("t1_reads", n_read - r0, 1);
    check("t1_latency", last_rise_cyc - frame_start, LATENCY);
    check("t1_ferr", n_ferr - f0, 0);
    check("t1_ovr", n_ovr - o0, 0);
    check("t1_sync_lost", sync_lost, 0);

    // 2: keystream stalls for 100 cycles
    keystream_valid = 1'b0; keystream_byte = 8'h00;
    r0 = n_read; a0 = n_acc;
    send_expect(8'h00, 8'h5A);
    repeat (100) @(negedge clk);
    check("t2_wait_pt_valid", pt_valid, 0);
    check("t2_wait_reads", n_read - r0, 0);
    keystream_byte = 8'h5A; keystream_valid = 1'b1;
    wait_acc("t2_accept", a0 + 1, 50);
    check("t2_pt_data", last_acc, 8'h5A);
    check("t2_reads", n_read - r0, 1);

    // 3: output stalled, third byte overruns
    keystream_byte = 8'h00; pt_ready = 1'b0;
    r0 = n_read; o0 = n_ovr; a0 = n_acc;
    send_expect(8'h11, 8'h00);
    send_expect(8'h22, 8'h00);
    send_frame(8'h33, 0, -1);
    repeat (2) @(negedge clk);
    check("t3_pt_valid", pt_valid, 1);
    check("t3_pt_data", pt_data, 8'h11);
    check("t3_ovr", n_ovr - o0, 1);
    check("t3_sync_lost", sync_lost, 1);
    check("t3_reads_stalled", n_read - r0, 1);
    pt_ready = 1'b1;
    wait_acc("t3_accept", a0 + 2, 20);
    repeat (20) @(negedge clk);
    check("t3_accepts", n_acc - a0, 2);
    check("t3_last", last_acc, 8'h22);
    check("t3_reads", n_read - r0, 2);
    check("t3_pt_valid_idle", pt_valid, 0);

    // 4: framing error then recovery
    keystream_byte = 8'h01;
    r0 = n_read; f0 = n_ferr; a0 = n_acc;
    send_frame(8'h47, 40, -1);
    repeat (5) @(negedge clk);
    check("t4_ferr", n_ferr - f0, 1);
    check("t4_sync_lost", sync_lost, 1);
    check("t4_pt_valid", pt_valid, 0);
    check("t4_reads_bad", n_read - r0, 0);
    check("t4_acc_bad", n_acc - a0, 0);
    send_expect(8'h47, 8'h01);
    wait_acc("t4_accept", a0 + 1, 50);
    check("t4_pt_data", last_acc, 8'h46);
    check("t4_reads", n_read - r0, 1);
    check("t4_ferr_once", n_ferr - f0, 1);

    // 5: short glitch on the line
    r0 = n_read; f0 = n_ferr; o0 = n_ovr; a0 = n_acc;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_reads", n_read - r0, 0);
    check("t5_ferr", n_ferr - f0, 0);
    check("t5_ovr", n_ovr - o0, 0);
    check("t5_acc", n_acc - a0, 0);
    check("t5_pt_valid", pt_valid, 0);

    // 6: reset mid-frame, then a clean frame
    keystream_byte = 8'h0F;
    send_frame(8'hC3, 0, 4);
    #1;
    check("t6_rst_pt_valid", pt_valid, 0);
    check("t6_rst_pt_data", pt_data, 8'h00);
    check("t6_rst_ks_read", keystream_read, 0);
    check("t6_rst_frame_err", frame_err, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_sync_lost", sync_lost, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    a0 = n_acc; r0 = n_read;
    send_expect(8'hF0, 8'h0F);
    wait_acc("t6_accept", a0 + 1, 50);
    check("t6_pt_data", last_acc, 8'hFF);
    check("t6_reads", n_read - r0, 1);
    check("t6_sync_lost", sync_lost, 0);

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
